// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the ID-stage branch resolver
//
// Purpose: FSM state encoding, supported funct3 codes, hazard-count width and
// a funct3 legality helper used by branch_resolve_ctrl and branch_fwd_mux.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STALL    = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Worst case is a load in EX: two bubbles before its data can be forwarded.
  localparam int HZ_W = 2;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE);
  endfunction

endpackage

// File: rtl/branch_fwd_mux.sv
// rtl/branch_fwd_mux.sv - per-source hazard count and operand forwarding mux
//
// Purpose: one instance per branch source register.
// Ports:
//   hz_rs_i            source register seen in ID during the accept cycle
//   op_rs_i            latched source register used while resolving
//   ex_* / mem_* / wb_* pipeline destination, write-enable and load flags
//   mem_alu_result_i   MEM-stage forwarding data
//   wb_data_i          WB-stage forwarding data
//   rf_data_i          register-file read data
//   hz_cnt_o           number of stall cycles this source needs (0..2)
//   operand_o          forwarded operand value
module branch_fwd_mux
  import branch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] hz_rs_i,
  input  logic [REG_AW-1:0] op_rs_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [WIDTH-1:0]  mem_alu_result_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  input  logic [WIDTH-1:0]  rf_data_i,
  output logic [HZ_W-1:0]   hz_cnt_o,
  output logic [WIDTH-1:0]  operand_o
);

  // x0 never carries a dependency, so it never stalls.
  always_comb begin
    hz_cnt_o = '0;
    if (hz_rs_i != '0) begin
      if (ex_mem_read_i && (ex_rd_i == hz_rs_i)) begin
        hz_cnt_o = HZ_W'(2);
      end else if ((ex_reg_write_i && (ex_rd_i == hz_rs_i)) ||
                   (mem_mem_read_i && (mem_rd_i == hz_rs_i))) begin
        hz_cnt_o = HZ_W'(1);
      end
    end
  end

  // Youngest producer wins: MEM before WB before the register file.
  always_comb begin
    operand_o = rf_data_i;
    if (op_rs_i == '0) begin
      operand_o = '0;
    end else if (mem_reg_write_i && (mem_rd_i == op_rs_i)) begin
      operand_o = mem_alu_result_i;
    end else if (wb_reg_write_i && (wb_rd_i == op_rs_i)) begin
      operand_o = wb_data_i;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage BEQ/BNE resolver driving an external equality comparator
//
// Purpose: accepts a conditional branch, stalls the front-end on operand
// hazards, presents forwarded operands to the comparator, and issues a
// one-cycle redirect/flush for taken branches.
// Ports:
//   Branch*            branch in ID (valid, funct3, PC, immediate, Rs1/Rs2)
//   Ex*/Mem*/Wb*       pipeline destination/write/load info and forwarding data
//   RfAddr1/2, RfData1/2  register-file read port
//   CmpData0/1, CmpEqual  external comparator operands and result
//   Stall, Redirect, Flush, TargetPC  front-end control
//   Done, IllegalBranch   status pulses
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchValid,
  input  logic [2:0]        BranchFunct3,
  input  logic [WIDTH-1:0]  BranchPC,
  input  logic [WIDTH-1:0]  BranchImm,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  input  logic [REG_AW-1:0] ExRd,
  input  logic [REG_AW-1:0] MemRd,
  input  logic [REG_AW-1:0] WbRd,
  input  logic              ExRegWrite,
  input  logic              MemRegWrite,
  input  logic              WbRegWrite,
  input  logic              ExMemRead,
  input  logic              MemMemRead,
  input  logic [WIDTH-1:0]  MemAluResult,
  input  logic [WIDTH-1:0]  WbData,
  output logic [REG_AW-1:0] RfAddr1,
  output logic [REG_AW-1:0] RfAddr2,
  input  logic [WIDTH-1:0]  RfData1,
  input  logic [WIDTH-1:0]  RfData2,
  output logic [WIDTH-1:0]  CmpData0,
  output logic [WIDTH-1:0]  CmpData1,
  input  logic              CmpEqual,
  output logic              Stall,
  output logic              Redirect,
  output logic              Flush,
  output logic [WIDTH-1:0]  TargetPC,
  output logic              Done,
  output logic              IllegalBranch
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [2:0]        f3_q, f3_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [HZ_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  logic [HZ_W-1:0]   hz1, hz2, hz_max;
  logic [WIDTH-1:0]  op0, op1;
  logic              taken;

  branch_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd1 (
    .hz_rs_i          (Rs1),
    .op_rs_i          (rs1_q),
    .ex_rd_i          (ExRd),
    .ex_reg_write_i   (ExRegWrite),
    .ex_mem_read_i    (ExMemRead),
    .mem_rd_i         (MemRd),
    .mem_reg_write_i  (MemRegWrite),
    .mem_mem_read_i   (MemMemRead),
    .wb_rd_i          (WbRd),
    .wb_reg_write_i   (WbRegWrite),
    .mem_alu_result_i (MemAluResult),
    .wb_data_i        (WbData),
    .rf_data_i        (RfData1),
    .hz_cnt_o         (hz1),
    .operand_o        (op0)
  );

  branch_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd2 (
    .hz_rs_i          (Rs2),
    .op_rs_i          (rs2_q),
    .ex_rd_i          (ExRd),
    .ex_reg_write_i   (ExRegWrite),
    .ex_mem_read_i    (ExMemRead),
    .mem_rd_i         (MemRd),
    .mem_reg_write_i  (MemRegWrite),
    .mem_mem_read_i   (MemMemRead),
    .wb_rd_i          (WbRd),
    .wb_reg_write_i   (WbRegWrite),
    .mem_alu_result_i (MemAluResult),
    .wb_data_i        (WbData),
    .rf_data_i        (RfData2),
    .hz_cnt_o         (hz2),
    .operand_o        (op1)
  );

  assign hz_max = (hz1 > hz2) ? hz1 : hz2;
  assign taken  = (f3_q == F3_BNE) ? !CmpEqual : CmpEqual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      imm_q     <= '0;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      f3_q      <= f3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    // Done follows RESOLVE by one cycle: it lands in REDIRECT when taken,
    // or in the first IDLE cycle when not taken.
    done_d    = (state_q == ST_RESOLVE);
    illegal_d = 1'b0;
    Stall     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (BranchValid) begin
          if (f3_legal(BranchFunct3)) begin
            Stall = 1'b1;
            pc_d  = BranchPC;
            imm_d = BranchImm;
            f3_d  = BranchFunct3;
            rs1_d = Rs1;
            rs2_d = Rs2;
            if (hz_max == '0) begin
              state_d = ST_RESOLVE;
            end else begin
              cnt_d   = hz_max;
              state_d = ST_STALL;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_STALL: begin
        // EX only sees bubbles while stalled, so the count is not re-evaluated.
        Stall = 1'b1;
        cnt_d = cnt_q - HZ_W'(1);
        if (cnt_q <= HZ_W'(1)) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        Stall = 1'b1;
        if (taken) begin
          target_d = pc_q + imm_q;
          state_d  = ST_REDIRECT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign RfAddr1       = rs1_q;
  assign RfAddr2       = rs2_q;
  assign CmpData0      = (state_q == ST_RESOLVE) ? op0 : '0;
  assign CmpData1      = (state_q == ST_RESOLVE) ? op1 : '0;
  assign Redirect      = (state_q == ST_REDIRECT);
  assign Flush         = (state_q == ST_REDIRECT);
  assign TargetPC      = target_q;
  assign Done          = done_q;
  assign IllegalBranch = illegal_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        BranchValid;
  logic [2:0]  BranchFunct3;
  logic [31:0] BranchPC, BranchImm;
  logic [4:0]  Rs1, Rs2, ExRd, MemRd, WbRd;
  logic        ExRegWrite, MemRegWrite, WbRegWrite, ExMemRead, MemMemRead;
  logic [31:0] MemAluResult, WbData;
  logic [4:0]  RfAddr1, RfAddr2;
  logic [31:0] RfData1, RfData2, CmpData0, CmpData1;
  logic        CmpEqual;
  logic        Stall, Redirect, Flush, Done, IllegalBranch;
  logic [31:0] TargetPC;

  always #5 clk = ~clk;

  // The comparator that lives one level up.
  assign CmpEqual = (CmpData0 == CmpData1);

  branch_resolve_ctrl #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .BranchValid(BranchValid), .BranchFunct3(BranchFunct3),
    .BranchPC(BranchPC), .BranchImm(BranchImm),
    .Rs1(Rs1), .Rs2(Rs2), .ExRd(ExRd), .MemRd(MemRd), .WbRd(WbRd),
    .ExRegWrite(ExRegWrite), .MemRegWrite(MemRegWrite), .WbRegWrite(WbRegWrite),
    .ExMemRead(ExMemRead), .MemMemRead(MemMemRead),
    .MemAluResult(MemAluResult), .WbData(WbData),
    .RfAddr1(RfAddr1), .RfAddr2(RfAddr2), .RfData1(RfData1), .RfData2(RfData2),
    .CmpData0(CmpData0), .CmpData1(CmpData1), .CmpEqual(CmpEqual),
    .Stall(Stall), .Redirect(Redirect), .Flush(Flush), .TargetPC(TargetPC),
    .Done(Done), .IllegalBranch(IllegalBranch)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic [4:0]  exrd;  logic exw, exld;
    logic [4:0]  memrd; logic memw, memld;
    logic [31:0] memalu;
    logic [4:0]  wbrd;  logic wbw;
    logic [31:0] wbd;
    int          exp_stalls;
    logic [31:0] exp_op0, exp_op1;
    logic        exp_taken;
    logic        illegal;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_target = 32'h0;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] rf1, input logic [31:0] rf2,
    input logic [4:0] exrd, input logic exw, input logic exld,
    input logic [4:0] memrd, input logic memw, input logic memld, input logic [31:0] memalu,
    input logic [4:0] wbrd, input logic wbw, input logic [31:0] wbd,
    input int st, input logic [31:0] op0, input logic [31:0] op1, input logic tk);
    vec_t v;
    v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rf1 = rf1; v.rf2 = rf2;
    v.exrd = exrd; v.exw = exw; v.exld = exld;
    v.memrd = memrd; v.memw = memw; v.memld = memld; v.memalu = memalu;
    v.wbrd = wbrd; v.wbw = wbw; v.wbd = wbd;
    v.exp_stalls = st; v.exp_op0 = op0; v.exp_op1 = op1; v.exp_taken = tk;
    v.illegal = !(f3 == 3'b000 || f3 == 3'b001);
    return v;
  endfunction

  // Reference model: stall cycles needed by one source register.
  function automatic int model_hz(input vec_t v, input logic [4:0] rs);
    int worst = 0;
    if (rs == 5'd0) return 0;
    if (v.exld && v.exrd == rs) worst = 2;
    if (worst < 1 && v.exw && !v.exld && v.exrd == rs) worst = 1;
    if (worst < 1 && v.memld && v.memrd == rs) worst = 1;
    return worst;
  endfunction

  function automatic logic [31:0] model_op(input vec_t v, input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'h0;
    if (v.memw && v.memrd == rs) return v.memalu;
    if (v.wbw && v.wbrd == rs) return v.wbd;
    return rf;
  endfunction

  function automatic vec_t model_fill(input vec_t v);
    vec_t r = v;
    int a = model_hz(v, v.rs1);
    int b = model_hz(v, v.rs2);
    r.exp_stalls = (a > b) ? a : b;
    r.exp_op0    = model_op(v, v.rs1, v.rf1);
    r.exp_op1    = model_op(v, v.rs2, v.rf2);
    r.exp_taken  = (v.f3 == 3'b001) ? (r.exp_op0 != r.exp_op1) : (r.exp_op0 == r.exp_op1);
    r.illegal    = 1'b0;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    BranchFunct3 = v.f3; BranchPC = v.pc; BranchImm = v.imm;
    Rs1 = v.rs1; Rs2 = v.rs2; RfData1 = v.rf1; RfData2 = v.rf2;
    ExRd = v.exrd; ExRegWrite = v.exw; ExMemRead = v.exld;
    MemRd = v.memrd; MemRegWrite = v.memw; MemMemRead = v.memld; MemAluResult = v.memalu;
    WbRd = v.wbrd; WbRegWrite = v.wbw; WbData = v.wbd;
  endtask

  task automatic run_vec(input vec_t v);
    int st;
    logic [31:0] new_tgt;
    @(negedge clk);
    drive(v);
    BranchValid = 1'b1;
    #1;
    if (v.illegal) begin
      chk("illegal_stall_n", Stall, 1'b0);
      @(negedge clk); BranchValid = 1'b0; #1;
      chk("illegal_pulse", IllegalBranch, 1'b1);
      chk("illegal_stall_n1", Stall, 1'b0);
      chk("illegal_done", Done, 1'b0);
      @(negedge clk); #1;
      chk("illegal_pulse_end", IllegalBranch, 1'b0);
      chk("illegal_stall_n2", Stall, 1'b0);
      return;
    end
    st = v.exp_stalls;
    new_tgt = v.exp_taken ? (v.pc + v.imm) : last_target;
    for (int k = 0; k <= st + 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        BranchValid = 1'b0;
        #1;
      end
      chk("stall", Stall, (k <= st + 1));
      chk("cmp0", CmpData0, (k == st + 1) ? v.exp_op0 : 32'h0);
      chk("cmp1", CmpData1, (k == st + 1) ? v.exp_op1 : 32'h0);
      if (k == st + 1) begin
        chk("rfaddr1", RfAddr1, v.rs1);
        chk("rfaddr2", RfAddr2, v.rs2);
      end
      chk("redirect", Redirect, (k == st + 2) && v.exp_taken);
      chk("flush", Flush, (k == st + 2) && v.exp_taken);
      chk("done", Done, (k == st + 2));
      chk("illegal_n", IllegalBranch, 1'b0);
      chk("target", TargetPC, (k >= st + 2) ? new_tgt : last_target);
    end
    last_target = new_tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    BranchValid = 1'b0;
    drive(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //             f3      pc            imm           rs1 rs2 rf1           rf2           exrd w ld memrd w ld memalu        wbrd w wbd           st op0           op1           tk
    tbl.push_back(mk(3'b000, 32'h100,      32'h20,       5,  6,  32'h01234567, 32'h01234567, 0,  0, 0, 0,   0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h01234567, 32'h01234567, 1));
    tbl.push_back(mk(3'b001, 32'h180,      32'h40,       7,  8,  32'h12de24f6, 32'h12de24f6, 0,  0, 0, 0,   0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h12de24f6, 32'h12de24f6, 0));
    tbl.push_back(mk(3'b000, 32'h200,      32'h40,       5,  6,  32'h11111111, 32'h76543210, 5,  1, 1, 5,   1, 0, 32'h76543210, 0,  0, 32'h0,        2, 32'h76543210, 32'h76543210, 1));
    tbl.push_back(mk(3'b000, 32'h300,      32'hFFFFFFF0, 0,  3,  32'hFFFFFFFF, 32'h0,        0,  1, 0, 0,   0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        1));
    tbl.push_back(mk(3'b100, 32'h340,      32'h4,        1,  2,  32'h0,        32'h0,        0,  0, 0, 0,   0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(3'b000, 32'hFFFFFFF0, 32'h20,       1,  2,  32'h5,        32'h5,        0,  0, 0, 0,   0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h5,        32'h5,        1));
    tbl.push_back(mk(3'b001, 32'h400,      32'h8,        9,  10, 32'h0,        32'h0,        10, 1, 0, 9,   1, 1, 32'hAAAA0000, 10, 1, 32'hAAAA0001, 1, 32'hAAAA0000, 32'hAAAA0001, 1));
    tbl.push_back(mk(3'b000, 32'h500,      32'h10,       4,  12, 32'h3,        32'h3,        4,  1, 1, 12,  0, 1, 32'h0,        12, 1, 32'h4,        2, 32'h3,        32'h4,        0));

    // Reset state.
    @(negedge clk); @(negedge clk); #1;
    chk("rst_stall", Stall, 1'b0);
    chk("rst_redirect", Redirect, 1'b0);
    chk("rst_flush", Flush, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_illegal", IllegalBranch, 1'b0);
    chk("rst_target", TargetPC, 32'h0);
    chk("rst_cmp0", CmpData0, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset in the middle of a STALL.
    @(negedge clk);
    drive(tbl[2]);
    BranchValid = 1'b1;
    @(negedge clk);
    BranchValid = 1'b0;
    #1;
    chk("pre_rst_stall", Stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", Stall, 1'b0);
    chk("arst_redirect", Redirect, 1'b0);
    chk("arst_flush", Flush, 1'b0);
    chk("arst_done", Done, 1'b0);
    chk("arst_illegal", IllegalBranch, 1'b0);
    chk("arst_target", TargetPC, 32'h0);
    chk("arst_cmp1", CmpData1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_target = 32'h0;
    run_vec(tbl[0]);

    // Randomized branches against the reference model.
    for (int n = 0; n < 60; n++) begin
      v.f3     = 3'($urandom_range(0, 1));
      v.pc     = $urandom;
      v.imm    = $urandom;
      v.rs1    = 5'($urandom_range(0, 3));
      v.rs2    = 5'($urandom_range(0, 3));
      v.rf1    = 32'hCAFE0000 | 32'($urandom_range(0, 1));
      v.rf2    = 32'hCAFE0000 | 32'($urandom_range(0, 1));
      v.exrd   = 5'($urandom_range(0, 3));
      v.exw    = 1'($urandom_range(0, 1));
      v.exld   = 1'($urandom_range(0, 1));
      v.memrd  = 5'($urandom_range(0, 3));
      v.memw   = 1'($urandom_range(0, 1));
      v.memld  = 1'($urandom_range(0, 1));
      v.memalu = 32'hCAFE0000 | 32'($urandom_range(0, 1));
      v.wbrd   = 5'($urandom_range(0, 3));
      v.wbw    = 1'($urandom_range(0, 1));
      v.wbd    = 32'hCAFE0000 | 32'($urandom_range(0, 1));
      run_vec(model_fill(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
